// File: rtl/pacman_grid_core.sv
// pacman_grid_core: grid playfield, rate-limited player, LFSR bean respawn,
// IDLE/PLAY/RESPAWN/WIN game FSM and a registered pixel/colour raster stream.
// Ports: clk, resetn (async, active-low), key[3:0] (R,L,U,D requests),
//   start (pulse); x, y, colour, frame_done (aligned raster outputs),
//   score, hex0 (active-low 7-seg of score), state.
// Option: define PACMAN_WRAP_EN to let edge moves wrap to the opposite edge.
module pacman_grid_core #(
   parameter int H_RES     = 320,
   parameter int V_RES     = 240,
   parameter int CELL_LOG2 = 4,
   parameter int GRID_COLS = 20,
   parameter int GRID_ROWS = 15,
   parameter int MOVE_DIV  = 5000000,
   parameter int SCORE_MAX = 9,
   parameter int START_C   = 10,
   parameter int START_R   = 11,
   parameter int BEAN_C    = 10,
   parameter int BEAN_R    = 7,
   parameter int OBS_C0    = 8,
   parameter int OBS_C1    = 11,
   parameter int OBS_R0    = 3,
   parameter int OBS_R1    = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [3:0]                     key,
   input  logic                           start,
   output logic [$clog2(H_RES)-1:0]       x,
   output logic [$clog2(V_RES)-1:0]       y,
   output logic [2:0]                     colour,
   output logic                           frame_done,
   output logic [$clog2(SCORE_MAX+1)-1:0] score,
   output logic [6:0]                     hex0,
   output logic [1:0]                     state
);

   localparam int XW   = $clog2(H_RES);
   localparam int YW   = $clog2(V_RES);
   localparam int CW   = $clog2(GRID_COLS);
   localparam int RW   = $clog2(GRID_ROWS);
   localparam int SW   = $clog2(SCORE_MAX+1);
   localparam int MW   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int CELL = 1 << CELL_LOG2;

`ifdef PACMAN_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_WIN  = 2'd3;

   localparam logic [CW-1:0] C_MAX = CW'(GRID_COLS-1);
   localparam logic [RW-1:0] R_MAX = RW'(GRID_ROWS-1);
   localparam logic [CW-1:0] ST_C  = CW'(START_C);
   localparam logic [RW-1:0] ST_R  = RW'(START_R);
   localparam logic [CW-1:0] BN_C  = CW'(BEAN_C);
   localparam logic [RW-1:0] BN_R  = RW'(BEAN_R);
   localparam logic [CW-1:0] OC0   = CW'(OBS_C0);
   localparam logic [CW-1:0] OC1   = CW'(OBS_C1);
   localparam logic [RW-1:0] OR0   = RW'(OBS_R0);
   localparam logic [RW-1:0] OR1   = RW'(OBS_R1);
   localparam logic [SW-1:0] S_MAX = SW'(SCORE_MAX);
   localparam logic [MW-1:0] M_MAX = MW'(MOVE_DIV-1);

   localparam logic [XW-1:0] SX_MAX  = XW'(H_RES-1);
   localparam logic [YW-1:0] SY_MAX  = YW'(V_RES-1);
   localparam logic [XW-1:0] G_COLS  = XW'(GRID_COLS);
   localparam logic [YW-1:0] G_ROWS  = YW'(GRID_ROWS);
   localparam logic [XW-1:0] GX_LAST = XW'((GRID_COLS << CELL_LOG2) - 1);
   localparam logic [YW-1:0] GY_LAST = YW'((GRID_ROWS << CELL_LOG2) - 1);
   localparam logic [CELL_LOG2-1:0] B_LO = CELL_LOG2'(CELL/4);
   localparam logic [CELL_LOG2-1:0] B_HI = CELL_LOG2'(3*CELL/4);

   function automatic logic is_obs(input logic [CW-1:0] c,
                                   input logic [RW-1:0] r);
      return (c >= OC0) && (c <= OC1) && (r >= OR0) && (r <= OR1);
   endfunction

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] pc_q, pc_d, bc_q, bc_d;
   logic [RW-1:0] pr_q, pr_d, br_q, br_d;
   logic [SW-1:0] score_q, score_d;
   logic [MW-1:0] mcnt_q, mcnt_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [XW-1:0] sx_q, sx_d, x_q;
   logic [YW-1:0] sy_q, sy_d, y_q;
   logic [2:0]    colour_q, colour_d;
   logic          fd_q, fd_d;

   logic          tick, hit, mv, wrapped, blocked, cand_ok;
   logic [CW-1:0] tc, cand_c;
   logic [RW-1:0] tr, cand_r;
   logic [SW-1:0] score_inc;

   assign tick      = (state_q == S_PLAY) && (mcnt_q == M_MAX);
   assign hit       = (pc_q == bc_q) && (pr_q == br_q);
   assign score_inc = score_q + 1'b1;
   assign cand_c    = lfsr_q[CW-1:0];
   assign cand_r    = lfsr_q[8+RW-1:8];
   assign cand_ok   = (cand_c <= C_MAX) && (cand_r <= R_MAX) &&
                      !is_obs(cand_c, cand_r) &&
                      !((cand_c == pc_q) && (cand_r == pr_q));

   // Target cell of the highest-priority requested move.
   always_comb begin
      tc      = pc_q;
      tr      = pr_q;
      mv      = 1'b0;
      wrapped = 1'b0;
      if (key[0]) begin
         mv = 1'b1;
         if (pc_q == C_MAX) begin
            tc      = '0;
            wrapped = 1'b1;
         end else begin
            tc = pc_q + 1'b1;
         end
      end else if (key[1]) begin
         mv = 1'b1;
         if (pc_q == '0) begin
            tc      = C_MAX;
            wrapped = 1'b1;
         end else begin
            tc = pc_q - 1'b1;
         end
      end else if (key[2]) begin
         mv = 1'b1;
         if (pr_q == '0) begin
            tr      = R_MAX;
            wrapped = 1'b1;
         end else begin
            tr = pr_q - 1'b1;
         end
      end else if (key[3]) begin
         mv = 1'b1;
         if (pr_q == R_MAX) begin
            tr      = '0;
            wrapped = 1'b1;
         end else begin
            tr = pr_q + 1'b1;
         end
      end
      blocked = (wrapped && !WRAP) || is_obs(tc, tr);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_PLAY;
         S_PLAY: if (hit) state_d = (score_inc == S_MAX) ? S_WIN : S_RESP;
         S_RESP: if (cand_ok) state_d = S_PLAY;
         S_WIN:  if (start) state_d = S_PLAY;
         default: state_d = S_IDLE;
      endcase
   end

   // Game datapath; a collection cycle takes precedence over a move.
   always_comb begin
      pc_d    = pc_q;
      pr_d    = pr_q;
      bc_d    = bc_q;
      br_d    = br_q;
      score_d = score_q;
      unique case (state_q)
         S_PLAY: begin
            if (hit) begin
               score_d = score_inc;
            end else if (tick && mv && !blocked) begin
               pc_d = tc;
               pr_d = tr;
            end
         end
         S_RESP: begin
            if (cand_ok) begin
               bc_d = cand_c;
               br_d = cand_r;
            end
         end
         S_WIN: begin
            if (start) begin
               pc_d    = ST_C;
               pr_d    = ST_R;
               bc_d    = BN_C;
               br_d    = BN_R;
               score_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      mcnt_d = '0;
      if (state_q == S_PLAY) mcnt_d = tick ? '0 : mcnt_q + 1'b1;
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      sx_d   = (sx_q == SX_MAX) ? '0 : sx_q + 1'b1;
      sy_d   = sy_q;
      if (sx_q == SX_MAX) sy_d = (sy_q == SY_MAX) ? '0 : sy_q + 1'b1;
      fd_d   = (sx_q == SX_MAX) && (sy_q == SY_MAX);
   end

   // Pixel colour for the current raster position.
   logic [XW-1:0]        gx;
   logic [YW-1:0]        gy;
   logic [CW-1:0]        gc;
   logic [RW-1:0]        gr;
   logic [CELL_LOG2-1:0] ox, oy;

   always_comb begin
      gx = sx_q >> CELL_LOG2;
      gy = sy_q >> CELL_LOG2;
      gc = gx[CW-1:0];
      gr = gy[RW-1:0];
      ox = sx_q[CELL_LOG2-1:0];
      oy = sy_q[CELL_LOG2-1:0];
      colour_d = 3'b000;
      if ((gx < G_COLS) && (gy < G_ROWS)) begin
         if ((gc == pc_q) && (gr == pr_q))
            colour_d = (state_q == S_WIN) ? 3'b110 : 3'b100;
         else if ((gc == bc_q) && (gr == br_q) &&
                  (ox >= B_LO) && (ox < B_HI) &&
                  (oy >= B_LO) && (oy < B_HI))
            colour_d = 3'b010;
         else if (is_obs(gc, gr))
            colour_d = 3'b111;
         else if ((sx_q == '0) || (sy_q == '0) ||
                  (sx_q == GX_LAST) || (sy_q == GY_LAST))
            colour_d = 3'b001;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q     <= ST_C;
         pr_q     <= ST_R;
         bc_q     <= BN_C;
         br_q     <= BN_R;
         score_q  <= '0;
         mcnt_q   <= '0;
         lfsr_q   <= 16'hACE1;
         sx_q     <= '0;
         sy_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         fd_q     <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         pr_q     <= pr_d;
         bc_q     <= bc_d;
         br_q     <= br_d;
         score_q  <= score_d;
         mcnt_q   <= mcnt_d;
         lfsr_q   <= lfsr_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         x_q      <= sx_q;
         y_q      <= sy_q;
         colour_q <= colour_d;
         fd_q     <= fd_d;
      end
   end

   logic [3:0] s4;

   always_comb begin
      s4 = 4'(score_q);
      unique case (s4)
         4'h0: hex0 = 7'b1000000;
         4'h1: hex0 = 7'b1111001;
         4'h2: hex0 = 7'b0100100;
         4'h3: hex0 = 7'b0110000;
         4'h4: hex0 = 7'b0011001;
         4'h5: hex0 = 7'b0010010;
         4'h6: hex0 = 7'b0000010;
         4'h7: hex0 = 7'b1111000;
         4'h8: hex0 = 7'b0000000;
         4'h9: hex0 = 7'b0010000;
         4'hA: hex0 = 7'b0001000;
         4'hB: hex0 = 7'b0000011;
         4'hC: hex0 = 7'b1000110;
         4'hD: hex0 = 7'b0100001;
         4'hE: hex0 = 7'b0000110;
         default: hex0 = 7'b0001110;
      endcase
   end

   assign x          = x_q;
   assign y          = y_q;
   assign colour     = colour_q;
   assign frame_done = fd_q;
   assign score      = score_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pacman_grid_core.sv
// Directed testbench for pacman_grid_core (MOVE_DIV=4).
// Player/bean/LFSR are observed through hierarchical references.
module tb_pacman_grid_core;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] key = 4'b0000;
   logic       start = 1'b0;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       frame_done;
   logic [3:0] score;
   logic [6:0] hex0;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   pacman_grid_core #(.MOVE_DIV(4)) dut (
      .clk(clk), .resetn(resetn), .key(key), .start(start),
      .x(x), .y(y), .colour(colour), .frame_done(frame_done),
      .score(score), .hex0(hex0), .state(state)
   );

   // Frame pulse expected exactly every 76800 cycles after reset release.
   always @(posedge clk) begin
      #1;
      if (!resetn) begin
         cyc = 0;
      end else begin
         cyc++;
         if ((cyc % 76800) == 0) begin
            checks++;
            pulses++;
            if (frame_done !== 1'b1 || x !== 9'd319 || y !== 8'd239) begin
               errors++;
               $display("FAIL frame_pulse cyc=%0d got fd=%b x=%0d y=%0d exp fd=1 x=319 y=239",
                        cyc, frame_done, x, y);
            end
         end else if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_spurious cyc=%0d got fd=1 exp 0", cyc);
         end
      end
   end

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      checks++;
      if (state !== 2'd0 || score !== 4'd0 || colour !== 3'd0) begin
         errors++;
         $display("FAIL reset_init got st=%0d sc=%0d col=%0d exp 0 0 0",
                  state, score, colour);
      end
      @(negedge clk) begin start = 1'b1; key = 4'b0001; end
      @(negedge clk) start = 1'b0;
      repeat (8) @(negedge clk);
      key = 4'b0000;
      checks++;
      if (dut.pc_q !== 5'd12 || dut.pr_q !== 4'd11) begin
         errors++;
         $display("FAIL reset_pre got (%0d,%0d) exp (12,11)", dut.pc_q, dut.pr_q);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (state !== 2'd0 || dut.pc_q !== 5'd10 || dut.pr_q !== 4'd11 ||
          score !== 4'd0 || colour !== 3'd0 || dut.lfsr_q !== 16'hACE1) begin
         errors++;
         $display("FAIL reset_async got st=%0d p=(%0d,%0d) sc=%0d col=%0d lfsr=%h exp 0 (10,11) 0 0 ace1",
                  state, dut.pc_q, dut.pr_q, score, colour, dut.lfsr_q);
      end
      @(negedge clk) resetn = 1'b1;
   endtask

   task automatic test_move;
      @(negedge clk) begin start = 1'b1; key = 4'b0001; end
      @(negedge clk) start = 1'b0;
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL start_play got st=%0d exp 1", state);
      end
      repeat (12) @(negedge clk);
      checks++;
      if (dut.pc_q !== 5'd13 || dut.pr_q !== 4'd11) begin
         errors++;
         $display("FAIL move_right3 got (%0d,%0d) exp (13,11)", dut.pc_q, dut.pr_q);
      end
      key = 4'b0011;
      repeat (4) @(negedge clk);
      key = 4'b0000;
      checks++;
      if (dut.pc_q !== 5'd14 || dut.pr_q !== 4'd11) begin
         errors++;
         $display("FAIL move_prio got (%0d,%0d) exp (14,11)", dut.pc_q, dut.pr_q);
      end
   endtask

   task automatic test_obstacle;
      @(negedge clk) begin force dut.pc_q = 5'd10; force dut.pr_q = 4'd5; end
      @(negedge clk) begin release dut.pc_q; release dut.pr_q; end
      key = 4'b0100;
      repeat (20) @(negedge clk);
      key = 4'b0000;
      checks++;
      if (dut.pc_q !== 5'd10 || dut.pr_q !== 4'd5) begin
         errors++;
         $display("FAIL obstacle_hold got (%0d,%0d) exp (10,5)", dut.pc_q, dut.pr_q);
      end
   endtask

   task automatic test_collect;
      bit moved = 1'b0;
      bit back = 1'b0;
      @(negedge clk) begin force dut.pc_q = 5'd10; force dut.pr_q = 4'd8; end
      @(negedge clk) begin release dut.pc_q; release dut.pr_q; end
      key = 4'b0100;
      for (int i = 0; i < 8 && !moved; i++) begin
         @(posedge clk);
         #1;
         if (dut.pr_q == 4'd7) moved = 1'b1;
      end
      key = 4'b0000;
      checks++;
      if (dut.pc_q !== 5'd10 || dut.pr_q !== 4'd7) begin
         errors++;
         $display("FAIL collect_move got (%0d,%0d) exp (10,7)", dut.pc_q, dut.pr_q);
      end
      @(posedge clk);
      #1;
      checks++;
      if (score !== 4'd1 || state !== 2'd2 || hex0 !== 7'b1111001) begin
         errors++;
         $display("FAIL collect_score got sc=%0d st=%0d hex=%b exp 1 2 1111001",
                  score, state, hex0);
      end
      for (int i = 0; i < 64 && !back; i++) begin
         @(posedge clk);
         #1;
         if (state == 2'd1) back = 1'b1;
      end
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL respawn_timeout got st=%0d exp 1", state);
      end
      checks++;
      if (dut.bc_q > 5'd19 || dut.br_q > 4'd14 ||
          (dut.bc_q >= 5'd8 && dut.bc_q <= 5'd11 && dut.br_q >= 4'd3 && dut.br_q <= 4'd4) ||
          (dut.bc_q == 5'd10 && dut.br_q == 4'd7)) begin
         errors++;
         $display("FAIL respawn_cell got (%0d,%0d) exp legal cell not (10,7)",
                  dut.bc_q, dut.br_q);
      end
   endtask

   task automatic test_win;
      logic [4:0] bc;
      logic [3:0] br;
      bit seen = 1'b0;
      @(negedge clk) force dut.score_q = 4'd8;
      @(negedge clk) release dut.score_q;
      checks++;
      if (score !== 4'd8) begin
         errors++;
         $display("FAIL win_preset got sc=%0d exp 8", score);
      end
      bc = dut.bc_q;
      br = dut.br_q;
      @(negedge clk) begin force dut.pc_q = bc; force dut.pr_q = br; end
      @(negedge clk) begin release dut.pc_q; release dut.pr_q; end
      checks++;
      if (score !== 4'd9 || state !== 2'd3 || hex0 !== 7'b0010000) begin
         errors++;
         $display("FAIL win_enter got sc=%0d st=%0d hex=%b exp 9 3 0010000",
                  score, state, hex0);
      end
      key = 4'b0001;
      for (int i = 0; i < 80000 && !seen; i++) begin
         @(negedge clk);
         if ((x >> 4) == 9'(bc) && (y >> 4) == 8'(br)) seen = 1'b1;
      end
      checks++;
      if (!seen || colour !== 3'b110) begin
         errors++;
         $display("FAIL win_colour got seen=%0d col=%b exp 1 110", seen, colour);
      end
      key = 4'b0000;
      checks++;
      if (dut.pc_q !== bc || dut.pr_q !== br || score !== 4'd9) begin
         errors++;
         $display("FAIL win_frozen got (%0d,%0d) sc=%0d exp (%0d,%0d) 9",
                  dut.pc_q, dut.pr_q, score, bc, br);
      end
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      checks++;
      if (state !== 2'd1 || score !== 4'd0 || dut.pc_q !== 5'd10 ||
          dut.pr_q !== 4'd11 || dut.bc_q !== 5'd10 || dut.br_q !== 4'd7) begin
         errors++;
         $display("FAIL win_restart got st=%0d sc=%0d p=(%0d,%0d) b=(%0d,%0d) exp 1 0 (10,11) (10,7)",
                  state, score, dut.pc_q, dut.pr_q, dut.bc_q, dut.br_q);
      end
   endtask

   task automatic test_wrap;
      logic [4:0] exp_c;
`ifdef PACMAN_WRAP_EN
      exp_c = 5'd19;
`else
      exp_c = 5'd0;
`endif
      @(negedge clk) begin force dut.pc_q = 5'd0; force dut.pr_q = 4'd11; end
      @(negedge clk) begin release dut.pc_q; release dut.pr_q; end
      key = 4'b0010;
      repeat (4) @(negedge clk);
      key = 4'b0000;
      checks++;
      if (dut.pc_q !== exp_c || dut.pr_q !== 4'd11) begin
         errors++;
         $display("FAIL edge_left got (%0d,%0d) exp (%0d,11)", dut.pc_q, dut.pr_q, exp_c);
      end
   endtask

   task automatic test_frame;
      for (int i = 0; i < 80000 && pulses == 0; i++) @(negedge clk);
      checks++;
      if (pulses == 0) begin
         errors++;
         $display("FAIL frame_timeout got no pulse exp one per 76800 cycles");
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_move();
      test_obstacle();
      test_collect();
      test_win();
      test_wrap();
      test_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
